// File: rtl/pn_join_net_if.sv
// Petri-net join channel bundle: producer deposits, consumer takes, fire enable and status.
interface pn_join_net_if #(
    parameter int N_IN  = 2,
    parameter int OUT_W = 3
);
    logic [N_IN-1:0]  in;
    logic [N_IN-1:0]  in_ready;
    logic             fire_en;
    logic             out_take;
    logic             out1;
    logic [OUT_W-1:0] out_count;
    logic             fire;
    logic             overflow;

    modport master (
        output in, fire_en, out_take,
        input  in_ready, out1, out_count, fire, overflow
    );

    modport slave (
        input  in, fire_en, out_take,
        output in_ready, out1, out_count, fire, overflow
    );
endinterface

// File: rtl/pn_join_net.sv
// N_IN-input Petri-net join into a bounded output place; deposit-to-out1 latency 2 cycles.
// Back-pressure: in_ready drops when a place is full and T cannot consume from it this cycle.
module pn_join_net #(
    parameter int N_IN    = 2,
    parameter int IN_CAP  = 3,
    parameter int OUT_CAP = 4,
    parameter int IN_W    = $clog2(IN_CAP + 1),
    parameter int OUT_W   = $clog2(OUT_CAP + 1)
) (
    input  logic         clk,
    input  logic         rst,
    pn_join_net_if.slave bus
);
    localparam logic [IN_W-1:0]  IN_CAP_V  = IN_W'(IN_CAP);
    localparam logic [OUT_W-1:0] OUT_CAP_V = OUT_W'(OUT_CAP);

    logic [IN_W-1:0]  in_count [N_IN];
    logic [OUT_W-1:0] out_count_q;
    logic             fire_q;
    logic             overflow_q;

    logic             all_marked;
    logic             take_ok;
    logic             fire_now;
    logic [N_IN-1:0]  ready;
    logic [N_IN-1:0]  dep;

    // T only sees registered counts; same-cycle deposits wait one cycle.
    always_comb begin
        all_marked = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (in_count[i] == '0) all_marked = 1'b0;
        end
        take_ok  = bus.out_take & (out_count_q != '0);
        fire_now = bus.fire_en & all_marked &
                   ((out_count_q - OUT_W'(take_ok)) < OUT_CAP_V);
        for (int i = 0; i < N_IN; i++) begin
            ready[i] = (in_count[i] < IN_CAP_V) | fire_now;
        end
        dep = bus.in & ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) in_count[i] <= '0;
            out_count_q <= '0;
            fire_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // Modular add/sub stays exact: a full place only accepts when T also consumes.
            for (int i = 0; i < N_IN; i++) begin
                in_count[i] <= in_count[i] + IN_W'(dep[i]) - IN_W'(fire_now);
            end
            out_count_q <= out_count_q + OUT_W'(fire_now) - OUT_W'(take_ok);
            fire_q      <= fire_now;
            overflow_q  <= overflow_q | (|(bus.in & ~ready));
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_count = out_count_q;
    assign bus.out1      = (out_count_q != '0);
    assign bus.fire      = fire_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/pn_join_net.md
Name: pn_join_net

Overview:
- Parametrised Petri-net join: N_IN bounded input places feed one transition T, which feeds one bounded output place.
- Each input place counts tokens deposited by its producer.
- T fires when every input place holds at least one token and the output place can accept one.
- The consumer drains output tokens with out_take.
- Successor to the fixed two-input, single-token join: adds channel count, place capacities, ready back-pressure, a fire enable, occupancy and error status.

Parameters:
- N_IN, 2, number of input places/channels (>=1).
- IN_CAP, 3, maximum tokens per input place (>=1).
- OUT_CAP, 4, maximum tokens in the output place (>=1).
- IN_W, $clog2(IN_CAP+1), input place counter width (derived).
- OUT_W, $clog2(OUT_CAP+1), output place counter width (derived).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  N_IN  per-channel token deposit request, one token per cycle while high.
- in_ready  output  N_IN  place i can accept a deposit this cycle.
- fire_en  input  1  transition enable; 0 freezes T, deposits and takes still proceed.
- out_take  input  1  consumer removes one output token this cycle.
- out1  output  1  output place non-empty (token available).
- out_count  output  OUT_W  output place occupancy.
- fire  output  1  registered pulse, high the cycle after T fired.
- overflow  output  1  sticky: a deposit was refused (in[i]=1 with in_ready[i]=0).

Behaviour:
- Reset (rst=0, asynchronous): all in_count[i]=0, out_count=0, out1=0, fire=0, overflow=0. in_ready comes out as all-ones, since places are empty.
- take_ok = out_take & (out_count>0). out_take on an empty place is ignored and is not an error.
- fire_now = fire_en & (all in_count[i]>=1) & ((out_count - take_ok) < OUT_CAP).
  - fire_now uses registered counts only; a deposit made in the same cycle is not visible to T.
  - A full output place with a simultaneous take still permits firing.
- in_ready[i] = (in_count[i] < IN_CAP) | fire_now. A full place accepts a deposit in the same cycle T consumes from it.
- dep[i] = in[i] & in_ready[i].
- Next-state update:
  - in_count[i] <= in_count[i] + dep[i] - fire_now.
  - out_count <= out_count + fire_now - take_ok.
  - All channels decrement together when T fires; counts never exceed capacity and never go below 0.
- fire <= fire_now. overflow <= overflow | any(in[i] & ~in_ready[i]). overflow clears only on reset.
- out1 = (out_count != 0), driven from the register, no combinational path from inputs.
- Latency: a deposit at edge k makes the place count visible after edge k; earliest firing at edge k+1; out1 high after edge k+1. First-token latency from in to out1 is 2 cycles.
- Throughput: one firing per cycle sustained while all inputs are deposited every cycle and out_take is high every cycle.
- Any channel whose place is empty blocks T; other places keep accumulating up to IN_CAP, then deassert in_ready.
- A mid-operation reset discards all tokens immediately, asynchronously. The first firing after reset release needs fresh deposits on every channel.
- Combinational paths:
  - in_ready depends on out_take and fire_en through fire_now.
  - The integrator must not make out_take depend on in_ready.

Test Plan:
- Basic join (N_IN=2): rst low 1 cycle; in=2'b11 for 2 cycles, then 0, out_take=0.
  -> 2 tokens per place; fire pulses on 2 consecutive cycles; out_count=2, out1=1; in_count returns to 0.
- Unbalanced channels: in[0] high 5 cycles, in[1] low, out_take=0.
  -> place 0 saturates at 3; in_ready[0]=0 from cycle 4; overflow=1 after cycle 4; no fire. Then in[1] high 3 cycles -> 3 firings, out_count=3.
- Output back-pressure: in=2'b11 continuously, out_take=0.
  -> out_count stops at 4; no further fire; input places fill to 3, in_ready=0. Then out_take=1 for 1 cycle -> one take and one fire in the same cycle, out_count stays 4.
- Steady stream: in=2'b11 and out_take=1 every cycle.
  -> after 2-cycle startup, fire=1 every cycle and out_count holds at 1; overflow stays 0.
- fire_en gating: tokens present, fire_en=0 for 4 cycles -> no fire, counts hold. fire_en=1 -> firing resumes the next cycle.
- Reset mid-run: rst low asynchronously with out_count=3 and in_count=2.
  -> all counts, out1, fire and overflow go to 0 immediately; in_ready=all ones; an empty out_take after release is ignored.
